// File: rtl/ahb_master_sequencer.sv
// AHB-lite master sequencer: round-robin arbitration between the fetch and data
// requesters onto one AHB-lite port, with wait-state and two-cycle error handling.
module ahb_master_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [2:0]        dm_size,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              bus_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [3:0]        hprot,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hr_data
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [3:0] HPROT_FETCH   = 4'b0010;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  state_e            state_q, state_d;
  logic              grant_dm_q, grant_dm_d;
  logic              rr_last_dm_q, rr_last_dm_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [3:0]        hprot_q, hprot_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              bus_err_q, bus_err_d;

  logic arb_open, any_req, pick_dm, dm_illegal;

  // A done pulse in flight blocks arbitration so the requester can drop req.
  always_comb begin
    arb_open   = ~(if_done_q | dm_done_q);
    any_req    = if_req | dm_req;
    pick_dm    = dm_req & (~if_req | ~rr_last_dm_q);
    dm_illegal = (dm_size > 3'd2)
               | ((dm_size == 3'd1) & dm_addr[0])
               | ((dm_size == 3'd2) & (dm_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_dm_q   <= 1'b0;
      rr_last_dm_q <= 1'b0;
      wdata_q      <= '0;
      haddr_q      <= '0;
      htrans_q     <= HTRANS_IDLE;
      hwrite_q     <= 1'b0;
      hsize_q      <= HSIZE_WORD;
      hprot_q      <= HPROT_DATA;
      hwdata_q     <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_dm_q   <= grant_dm_d;
      rr_last_dm_q <= rr_last_dm_d;
      wdata_q      <= wdata_d;
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      hprot_q      <= hprot_d;
      hwdata_q     <= hwdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arb_open && any_req && !(pick_dm && dm_illegal)) state_d = S_ADDR;
      S_ADDR: if (hready) state_d = S_DATA;
      S_DATA: begin
        if (hready)     state_d = S_IDLE;
        else if (hresp) state_d = S_ERR;
      end
      S_ERR:  if (hready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_dm_d   = grant_dm_q;
    rr_last_dm_d = rr_last_dm_q;
    wdata_d      = wdata_q;
    haddr_d      = haddr_q;
    htrans_d     = htrans_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    hprot_d      = hprot_q;
    hwdata_d     = hwdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_open && any_req) begin
          rr_last_dm_d = pick_dm;
          grant_dm_d   = pick_dm;
          if (pick_dm && dm_illegal) begin
            dm_done_d = 1'b1;
            bus_err_d = 1'b1;
          end else if (pick_dm) begin
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = dm_addr;
            hwrite_d = dm_write;
            hsize_d  = dm_size;
            hprot_d  = HPROT_DATA;
            wdata_d  = dm_wdata;
          end else begin
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = if_addr;
            hwrite_d = 1'b0;
            hsize_d  = HSIZE_WORD;
            hprot_d  = HPROT_FETCH;
            wdata_d  = '0;
          end
        end
      end
      S_ADDR: begin
        if (hready) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
        end
      end
      S_DATA: begin
        // An hready=1 error response is treated as a completed failed transfer.
        if (hready) begin
          if (grant_dm_q) dm_done_d = 1'b1;
          else            if_done_d = 1'b1;
          bus_err_d = hresp;
          if (!hresp && !hwrite_q) begin
            if (grant_dm_q) dm_rdata_d = hr_data;
            else            if_rdata_d = hr_data;
          end
        end
      end
      S_ERR: begin
        if (hready) begin
          if (grant_dm_q) dm_done_d = 1'b1;
          else            if_done_d = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign haddr    = haddr_q;
  assign htrans   = htrans_q;
  assign hwrite   = hwrite_q;
  assign hsize    = hsize_q;
  assign hprot    = hprot_q;
  assign hwdata   = hwdata_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_done  = if_done_q;
  assign dm_done  = dm_done_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_ahb_master_sequencer.sv
// Directed bench for ahb_master_sequencer: inputs driven and outputs sampled on
// the falling clock edge, expected values worked out by hand from the protocol.
module tb_ahb_master_sequencer;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [2:0]        dm_size;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              bus_err;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hr_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  logic exp_dm;

  ahb_master_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_write(dm_write), .dm_addr(dm_addr), .dm_size(dm_size),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata), .bus_err(bus_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hr_data(hr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(if_done || dm_done) && n < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_write = 1'b0;
    dm_addr = '0; dm_size = 3'd2; dm_wdata = '0; hready = 1'b1; hresp = 1'b0; hr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_htrans", 32'(htrans), 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_hsize", 32'(hsize), 32'h2);
    check("rst_hprot", 32'(hprot), 32'h3);
    check("rst_hwrite", 32'(hwrite), 32'h0);
    check("rst_dones", 32'({if_done, dm_done, bus_err}), 32'h0);
    check("rst_rdata", if_rdata | dm_rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // fetch, zero wait states
    if_req = 1'b1; if_addr = 32'h0000_0010; hr_data = 32'h0050_0093;
    @(negedge clk);
    check("t1_htrans_nonseq", 32'(htrans), 32'h2);
    check("t1_haddr", haddr, 32'h10);
    check("t1_hprot", 32'(hprot), 32'h2);
    check("t1_hsize", 32'(hsize), 32'h2);
    check("t1_hwrite", 32'(hwrite), 32'h0);
    @(negedge clk);
    check("t1_dphase_htrans", 32'(htrans), 32'h0);
    check("t1_no_early_done", 32'(if_done), 32'h0);
    @(negedge clk);
    check("t1_if_done", 32'(if_done), 32'h1);
    check("t1_if_rdata", if_rdata, 32'h0050_0093);
    check("t1_bus_err", 32'(bus_err), 32'h0);
    check("t1_dm_done", 32'(dm_done), 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_done_pulse", 32'(if_done), 32'h0);

    // store word with two data-phase wait states
    dm_req = 1'b1; dm_write = 1'b1; dm_addr = 32'h2000_0004; dm_size = 3'd2;
    dm_wdata = 32'hDEAD_BEEF; hr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t2_htrans", 32'(htrans), 32'h2);
    check("t2_hwrite", 32'(hwrite), 32'h1);
    check("t2_hprot", 32'(hprot), 32'h3);
    check("t2_haddr", haddr, 32'h2000_0004);
    @(negedge clk);
    hready = 1'b0;
    check("t2_hwdata_c2", hwdata, 32'hDEAD_BEEF);
    check("t2_htrans_c2", 32'(htrans), 32'h0);
    @(negedge clk);
    check("t2_hwdata_c3", hwdata, 32'hDEAD_BEEF);
    check("t2_wait_c3", 32'(dm_done), 32'h0);
    @(negedge clk);
    hready = 1'b1;
    check("t2_hwdata_c4", hwdata, 32'hDEAD_BEEF);
    check("t2_wait_c4", 32'(dm_done), 32'h0);
    @(negedge clk);
    check("t2_dm_done", 32'(dm_done), 32'h1);
    check("t2_bus_err", 32'(bus_err), 32'h0);
    check("t2_dm_rdata_kept", dm_rdata, 32'h0);
    dm_req = 1'b0; dm_write = 1'b0;
    @(negedge clk);

    // round-robin from reset: data, fetch, data, fetch
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t3_rst_if_rdata", if_rdata, 32'h0);
    @(negedge clk);
    dm_addr = 32'h3000_0000; dm_size = 3'd2; dm_write = 1'b0; if_addr = 32'h0000_0100;
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_dm  = (k % 2 == 0);
      hr_data = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      check("t3_haddr", haddr, exp_dm ? 32'h3000_0000 : 32'h0000_0100);
      check("t3_hprot", 32'(hprot), exp_dm ? 32'h3 : 32'h2);
      wait_done(cyc);
      check("t3_latency", 32'(cyc), 32'h2);
      check("t3_dm_done", 32'(dm_done), 32'(exp_dm));
      check("t3_if_done", 32'(if_done), 32'(!exp_dm));
      check("t3_bus_err", 32'(bus_err), 32'h0);
      if (exp_dm) check("t3_dm_rdata", dm_rdata, 32'hA000_0000 + 32'(k));
      else        check("t3_if_rdata", if_rdata, 32'hA000_0000 + 32'(k));
      if (k == 3) begin
        if_req = 1'b0; dm_req = 1'b0;
      end else if (exp_dm) dm_req = 1'b0;
      else                 if_req = 1'b0;
      @(negedge clk);
      if (k < 3) begin
        if (exp_dm) dm_req = 1'b1;
        else        if_req = 1'b1;
      end
    end

    // load with a two-cycle error response
    dm_req = 1'b1; dm_addr = 32'h2000_0008; dm_size = 3'd2; dm_write = 1'b0;
    hr_data = 32'h1234_5678;
    @(negedge clk);
    check("t4_htrans", 32'(htrans), 32'h2);
    @(negedge clk);
    hready = 1'b0; hresp = 1'b1;
    @(negedge clk);
    hready = 1'b1; hresp = 1'b1;
    check("t4_err_c1_no_done", 32'(dm_done), 32'h0);
    check("t4_err_htrans", 32'(htrans), 32'h0);
    @(negedge clk);
    hresp = 1'b0;
    check("t4_dm_done", 32'(dm_done), 32'h1);
    check("t4_bus_err", 32'(bus_err), 32'h1);
    check("t4_dm_rdata_kept", dm_rdata, 32'hA000_0002);
    check("t4_if_done", 32'(if_done), 32'h0);
    dm_req = 1'b0;
    @(negedge clk);
    check("t4_bus_err_clear", 32'(bus_err), 32'h0);

    // misaligned half-word load, then a fetch raised while done is high
    dm_req = 1'b1; dm_addr = 32'h2000_0003; dm_size = 3'd1;
    @(negedge clk);
    check("t5_no_transfer", 32'(htrans), 32'h0);
    check("t5_dm_done", 32'(dm_done), 32'h1);
    check("t5_bus_err", 32'(bus_err), 32'h1);
    check("t5_dm_rdata_kept", dm_rdata, 32'hA000_0002);
    dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0044; hr_data = 32'h0000_0013;
    @(negedge clk);
    check("t5_arb_blocked", 32'(htrans), 32'h0);
    @(negedge clk);
    check("t5_fetch_nonseq", 32'(htrans), 32'h2);
    check("t5_fetch_haddr", haddr, 32'h44);
    wait_done(cyc);
    check("t5_fetch_latency", 32'(cyc), 32'h2);
    check("t5_if_done", 32'(if_done), 32'h1);
    check("t5_if_rdata", if_rdata, 32'h0000_0013);
    check("t5_bus_err", 32'(bus_err), 32'h0);
    if_req = 1'b0;
    @(negedge clk);

    // asynchronous reset while the address phase is stalled
    if_req = 1'b1; if_addr = 32'h0000_0080; hready = 1'b0;
    @(negedge clk);
    check("t6_nonseq", 32'(htrans), 32'h2);
    @(negedge clk);
    check("t6_addr_hold", haddr, 32'h80);
    check("t6_nonseq_hold", 32'(htrans), 32'h2);
    #2 reset = 1'b0;
    #1;
    check("t6_async_htrans", 32'(htrans), 32'h0);
    check("t6_async_haddr", haddr, 32'h0);
    if_req = 1'b0; hready = 1'b1;
    @(negedge clk);
    check("t6_no_done_in_reset", 32'(if_done), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_no_done_after", 32'({if_done, dm_done}), 32'h0);
    check("t6_idle_after", 32'(htrans), 32'h0);
    if_req = 1'b1; if_addr = 32'h0000_0090; hr_data = 32'h0000_6F00;
    wait_done(cyc);
    check("t6_fetch_latency", 32'(cyc), 32'h3);
    check("t6_if_done", 32'(if_done), 32'h1);
    check("t6_if_rdata", if_rdata, 32'h0000_6F00);
    if_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
